// File: rtl/mem_arbiter_pkg.sv
// Shared memory-bus types for the port arbiter: request/response bundles,
// the mask and command encodings, the in-order tag entry, and the load
// extraction helper used on the response path.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    M_X   = 2'd0,
    M_XRD = 2'd1,
    M_XWR = 2'd2
  } MemoryWriteSignal;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd4,
    MT_HU = 3'd5
  } MemoryMaskType;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    MemoryWriteSignal fcn;
    MemoryMaskType    typ;
  } MemoryRequest;

  typedef struct packed {
    logic [31:0] data;
  } MemoryResponse;

  // Everything needed to route and post-process one downstream response.
  // The port field is sized for the largest supported port count (8).
  typedef struct packed {
    logic [2:0]       port;
    MemoryMaskType    typ;
    logic [1:0]       addr_lo;
    MemoryWriteSignal fcn;
  } TagEntry;

  // Select the addressed byte/half of a returned word and extend it.
  // Writes and MT_X carry no load data and return zero.
  function automatic logic [31:0] extract_load(input logic [31:0]      word,
                                               input MemoryMaskType    typ,
                                               input logic [1:0]       addr_lo,
                                               input MemoryWriteSignal fcn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    extract_load = '0;
    if (fcn != M_XWR) begin
      case (typ)
        MT_B:    extract_load = {{24{b[7]}}, b};
        MT_BU:   extract_load = {24'd0, b};
        MT_H:    extract_load = {{16{h[15]}}, h};
        MT_HU:   extract_load = {16'd0, h};
        MT_W:    extract_load = word;
        default: extract_load = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy outputs.
// Used for the per-port request queues and the in-order tag queue.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two and single-entry depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: per-port request queues, round-robin grant onto
// a single downstream request channel with an outstanding-request limit, and
// in-order response routing with byte/half extraction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int QUEUE_DEPTH     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] port_req_valid,
  input  MemoryRequest         port_req [NUM_PORTS],
  output logic [NUM_PORTS-1:0] port_req_ready,
  output logic [NUM_PORTS-1:0] port_res_valid,
  output MemoryResponse        port_res [NUM_PORTS],
  output logic                 mem_req_valid,
  output MemoryRequest         mem_req,
  input  logic                 mem_req_ready,
  input  logic                 mem_res_valid,
  input  MemoryResponse        mem_res,
  output logic                 err_orphan_res
);

  localparam int PW  = $clog2(NUM_PORTS);
  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

  logic                 ready_en;
  logic [NUM_PORTS-1:0] q_push;
  logic [NUM_PORTS-1:0] q_pop;
  logic [NUM_PORTS-1:0] q_full;
  logic [NUM_PORTS-1:0] q_empty;
  MemoryRequest         q_head [NUM_PORTS];
  logic [QCW-1:0]       unused_q_count [NUM_PORTS];

  logic [PW-1:0]        last_grant;
  logic [PW-1:0]        rr_sel;
  logic [PW-1:0]        cand;
  logic                 rr_found;
  logic                 hold;
  logic [PW-1:0]        hold_port;
  logic [PW-1:0]        sel;
  logic                 issue;

  TagEntry              tag_in;
  TagEntry              tag_head;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 tag_full;
  logic                 tag_empty;
  logic [TCW-1:0]       outstanding;

  logic [31:0]          res_data;
  logic [NUM_PORTS-1:0] res_strobe;

  // Per-port request queues; ready is held low through reset and while full.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
      assign port_req_ready[gi] = ready_en & ~q_full[gi];
      assign q_push[gi]         = port_req_valid[gi] & port_req_ready[gi];
      assign q_pop[gi]          = issue && (sel == PW'(gi));
      assign port_res[gi].data  = res_data;

      sync_fifo #(
        .WIDTH ($bits(MemoryRequest)),
        .DEPTH (QUEUE_DEPTH)
      ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (q_push[gi]),
        .push_data (port_req[gi]),
        .pop       (q_pop[gi]),
        .pop_data  (q_head[gi]),
        .count     (unused_q_count[gi]),
        .full      (q_full[gi]),
        .empty     (q_empty[gi])
      );
    end
  endgenerate

  // Round-robin search over non-empty queues starting after the last grant.
  always_comb begin
    rr_sel   = last_grant;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(last_grant) + k) % NUM_PORTS);
      if (!rr_found && !q_empty[cand]) begin
        rr_sel   = cand;
        rr_found = 1'b1;
      end
    end
  end

  // A stalled offer stays locked on its port so mem_req cannot change
  // under a higher-priority arrival; the limit check uses the count
  // before any same-cycle retire.
  assign sel           = hold ? hold_port : rr_sel;
  assign mem_req_valid = !q_empty[sel] && (outstanding != TCW'(MAX_OUTSTANDING));
  assign mem_req       = mem_req_valid ? q_head[sel] : '0;
  assign issue         = mem_req_valid && mem_req_ready;

  // Grant pointer, stall lock and post-reset ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PW'(NUM_PORTS - 1);
      hold       <= 1'b0;
      hold_port  <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      hold      <= mem_req_valid && !mem_req_ready;
      hold_port <= sel;
      if (issue) last_grant <= sel;
    end
  end

  // Tag captured on each downstream handshake, in issue order.
  always_comb begin
    tag_in         = '0;
    tag_in.port    = 3'(sel);
    tag_in.typ     = mem_req.typ;
    tag_in.addr_lo = mem_req.addr[1:0];
    tag_in.fcn     = mem_req.fcn;
  end

  assign tag_push = issue && !tag_full;
  assign tag_pop  = mem_res_valid && !tag_empty;

  sync_fifo #(
    .WIDTH ($bits(TagEntry)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .count     (outstanding),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Registered response routing and the sticky orphan-response flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_strobe     <= '0;
      res_data       <= '0;
      err_orphan_res <= 1'b0;
    end else begin
      res_strobe <= '0;
      if (mem_res_valid) begin
        if (tag_empty) begin
          err_orphan_res <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            res_strobe[i] <= (tag_head.port == 3'(i));
          end
          res_data <= extract_load(mem_res.data, tag_head.typ,
                                   tag_head.addr_lo, tag_head.fcn);
        end
      end
    end
  end

  assign port_res_valid = res_strobe;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (2 ports, depth 2, 4 outstanding).
// A driver feeds per-port stimulus queues, a downstream model echoes each
// request's data word back as the response, and a negedge monitor scores
// every port response against the expected value queued at acceptance.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    MemoryRequest req;
    logic [31:0]  exp;
  } stim_t;

  logic          clk;
  logic          reset_n;
  logic [1:0]    port_req_valid;
  MemoryRequest  port_req [2];
  logic [1:0]    port_req_ready;
  logic [1:0]    port_res_valid;
  MemoryResponse port_res [2];
  logic          mem_req_valid;
  MemoryRequest  mem_req;
  logic          mem_req_ready;
  logic          mem_res_valid;
  MemoryResponse mem_res;
  logic          err_orphan_res;

  int checks = 0;
  int errors = 0;

  stim_t       stim_q [2][$];
  logic [31:0] exp_q  [2][$];
  logic [31:0] inflight[$];
  logic [31:0] grant_log[$];
  logic [1:0]  accepted;
  int          resp_budget;
  logic        orphan_req;

  mem_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .port_req_valid (port_req_valid),
    .port_req       (port_req),
    .port_req_ready (port_req_ready),
    .port_res_valid (port_res_valid),
    .port_res       (port_res),
    .mem_req_valid  (mem_req_valid),
    .mem_req        (mem_req),
    .mem_req_ready  (mem_req_ready),
    .mem_res_valid  (mem_res_valid),
    .mem_res        (mem_res),
    .err_orphan_res (err_orphan_res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic MemoryRequest mk(input logic [31:0] addr, input logic [31:0] data,
                                      input MemoryWriteSignal fcn, input MemoryMaskType typ);
    MemoryRequest r;
    r.addr = addr;
    r.data = data;
    r.fcn  = fcn;
    r.typ  = typ;
    return r;
  endfunction

  task automatic add_stim(input int p, input MemoryRequest r, input logic [31:0] exp);
    stim_t s;
    s.req = r;
    s.exp = exp;
    stim_q[p].push_back(s);
  endtask

  task automatic main_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size() +
            inflight.size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check(name, 64'(exp_q[0].size() + exp_q[1].size() + stim_q[0].size() + stim_q[1].size()), 64'd0);
  endtask

  task automatic wait_grants(input string name, input int n);
    int t;
    t = 0;
    while (grant_log.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(grant_log.size() >= n), 64'd1);
  endtask

  task automatic clear_tb_queues();
    stim_q[0].delete();
    stim_q[1].delete();
    exp_q[0].delete();
    exp_q[1].delete();
    accepted = 2'b00;
  endtask

  // Request driver: present the head of each stimulus queue until accepted.
  initial begin
    port_req_valid = 2'b00;
    port_req[0]    = '0;
    port_req[1]    = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (accepted[i]) begin
          if (stim_q[i].size() > 0) void'(stim_q[i].pop_front());
          accepted[i] = 1'b0;
        end
        if (stim_q[i].size() > 0) begin
          port_req_valid[i] = 1'b1;
          port_req[i]       = stim_q[i][0].req;
        end else begin
          port_req_valid[i] = 1'b0;
          port_req[i]       = '0;
        end
      end
    end
  end

  // Downstream model: in-order echo of request data, throttled by a budget.
  initial begin
    mem_res_valid = 1'b0;
    mem_res       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_budget > 0 && inflight.size() > 0) begin
        mem_res_valid = 1'b1;
        mem_res.data  = inflight.pop_front();
        resp_budget--;
      end else if (orphan_req) begin
        mem_res_valid = 1'b1;
        mem_res.data  = 32'hDEAD_0001;
        orphan_req    = 1'b0;
      end else begin
        mem_res_valid = 1'b0;
        mem_res       = '0;
      end
    end
  end

  // Monitor: acceptance, downstream handshakes and scoreboarded responses.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset_n && port_req_valid[i] && port_req_ready[i] && stim_q[i].size() > 0) begin
          accepted[i] = 1'b1;
          exp_q[i].push_back(stim_q[i][0].exp);
        end
      end
      if (reset_n && mem_req_valid && mem_req_ready) begin
        inflight.push_back(mem_req.data);
        grant_log.push_back(mem_req.addr);
      end
      for (int i = 0; i < 2; i++) begin
        if (port_res_valid[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL port_res_unexpected[%0d]: got response %h, expected none", i, port_res[i].data);
          end else begin
            logic [31:0] e;
            e = exp_q[i].pop_front();
            if (port_res[i].data !== e) begin
              errors++;
              $display("FAIL port_res[%0d]: got %h expected %h", i, port_res[i].data, e);
            end else begin
              $display("res port%0d data=%h", i, port_res[i].data);
            end
          end
        end
      end
    end
  end

  logic [31:0]      l_addr [10] = '{32'h103, 32'h203, 32'h302, 32'h402, 32'h500,
                                    32'h601, 32'h700, 32'h800, 32'h900, 32'hA01};
  MemoryMaskType    l_typ  [10] = '{MT_B, MT_BU, MT_HU, MT_H, MT_H,
                                    MT_B, MT_W, MT_W, MT_X, MT_BU};
  MemoryWriteSignal l_fcn  [10] = '{M_XRD, M_XRD, M_XRD, M_XRD, M_XRD,
                                    M_XRD, M_XRD, M_XWR, M_XRD, M_XRD};
  logic [31:0]      l_exp  [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AA, 32'hFFFF_80AA,
                                    32'hFFFF_BBCC, 32'hFFFF_FFBB, 32'h80AA_BBCC, 32'h0000_0000,
                                    32'h0000_0000, 32'h0000_00BB};

  initial begin
    int base;
    int t;
    reset_n       = 1'b0;
    mem_req_ready = 1'b0;
    resp_budget   = 0;
    orphan_req    = 1'b0;
    accepted      = 2'b00;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(port_req_ready), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_req_addr", 64'(mem_req.addr), 64'd0);
    check("rst_res_valid", 64'(port_res_valid), 64'd0);
    check("rst_err", 64'(err_orphan_res), 64'd0);
    main_step();
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", 64'(port_req_ready), 64'd3);

    // Both ports busy, downstream always ready: grants alternate 0,1,0,1.
    main_step();
    mem_req_ready = 1'b1;
    resp_budget   = 1000000;
    base = grant_log.size();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        add_stim(p, mk(32'(p) << 28 | 32'(k) << 4, 32'hA000_0000 | 32'(p) << 8 | 32'(k),
                       M_XRD, MT_W),
                 32'hA000_0000 | 32'(p) << 8 | 32'(k));
      end
    end
    wait_grants("alt_grants_seen", base + 8);
    for (int j = 0; j < 8; j++) begin
      if (base + j < grant_log.size())
        check($sformatf("alt_grant_%0d", j), 64'(grant_log[base + j][31:28]), 64'(j % 2));
    end
    wait_drain("alt_drain");

    // Stall: a held offer from port 1 stays put while port 0 fills its queue.
    main_step();
    mem_req_ready = 1'b0;
    base = grant_log.size();
    add_stim(1, mk(32'h1000_0100, 32'h1111_0001, M_XRD, MT_W), 32'h1111_0001);
    repeat (3) @(negedge clk);
    check("stall_valid", 64'(mem_req_valid), 64'd1);
    check("stall_addr_p1", 64'(mem_req.addr), 64'h1000_0100);
    main_step();
    for (int k = 0; k < 3; k++)
      add_stim(0, mk(32'h0000_0200 + 32'(k) * 16, 32'h2222_0000 + 32'(k), M_XRD, MT_W),
               32'h2222_0000 + 32'(k));
    repeat (5) @(negedge clk);
    check("stall_ready0_low", 64'(port_req_ready[0]), 64'd0);
    check("stall_ready1_high", 64'(port_req_ready[1]), 64'd1);
    check("stall_addr_held", 64'(mem_req.addr), 64'h1000_0100);
    check("stall_valid_held", 64'(mem_req_valid), 64'd1);
    main_step();
    mem_req_ready = 1'b1;
    wait_drain("stall_drain");
    if (grant_log.size() > base)
      check("stall_first_grant", 64'(grant_log[base]), 64'h1000_0100);
    else
      check("stall_first_grant", 64'd0, 64'h1000_0100);

    // Load extraction and write/MT_X zeroing.
    main_step();
    for (int k = 0; k < 10; k++)
      add_stim(0, mk(l_addr[k], 32'h80AA_BBCC, l_fcn[k], l_typ[k]), l_exp[k]);
    wait_drain("extract_drain");

    // Outstanding limit: four in flight, a fifth waits until a retire lands.
    main_step();
    resp_budget = 0;
    base = grant_log.size();
    for (int k = 0; k < 3; k++)
      add_stim(0, mk(32'h0000_3000 + 32'(k) * 16, 32'h3333_0000 + 32'(k), M_XRD, MT_W),
               32'h3333_0000 + 32'(k));
    for (int k = 0; k < 2; k++)
      add_stim(1, mk(32'h1000_3000 + 32'(k) * 16, 32'h4444_0000 + 32'(k), M_XRD, MT_W),
               32'h4444_0000 + 32'(k));
    wait_grants("limit_four_issued", base + 4);
    repeat (3) @(negedge clk);
    check("limit_valid_low", 64'(mem_req_valid), 64'd0);
    check("limit_no_fifth", 64'(grant_log.size() - base), 64'd4);
    main_step();
    resp_budget = 1;
    t = 0;
    @(negedge clk);
    while (!mem_res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("limit_res_seen", 64'(mem_res_valid), 64'd1);
    check("limit_retire_no_issue", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    check("limit_issue_next", 64'(mem_req_valid), 64'd1);
    main_step();
    resp_budget = 1000000;
    wait_drain("limit_drain");

    // Orphan response after reset with nothing outstanding.
    main_step();
    reset_n = 1'b0;
    clear_tb_queues();
    main_step();
    main_step();
    reset_n = 1'b1;
    main_step();
    @(negedge clk);
    check("orphan_err_clear", 64'(err_orphan_res), 64'd0);
    main_step();
    orphan_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("orphan_no_res_%0d", j), 64'(port_res_valid), 64'd0);
    end
    check("orphan_err_set", 64'(err_orphan_res), 64'd1);
    repeat (5) @(negedge clk);
    check("orphan_err_held", 64'(err_orphan_res), 64'd1);

    // Reset pulsed mid-burst with responses held; they return as orphans.
    main_step();
    reset_n = 1'b0;
    main_step();
    reset_n = 1'b1;
    main_step();
    resp_budget = 0;
    for (int k = 0; k < 3; k++) begin
      add_stim(0, mk(32'h0000_5000 + 32'(k) * 16, 32'h5555_0000 + 32'(k), M_XRD, MT_W), 32'h5555_0000 + 32'(k));
      add_stim(1, mk(32'h1000_5000 + 32'(k) * 16, 32'h6666_0000 + 32'(k), M_XRD, MT_W), 32'h6666_0000 + 32'(k));
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("midrst_mem_req_addr", 64'(mem_req.addr), 64'd0);
    check("midrst_req_ready", 64'(port_req_ready), 64'd0);
    check("midrst_res_valid", 64'(port_res_valid), 64'd0);
    check("midrst_err", 64'(err_orphan_res), 64'd0);
    clear_tb_queues();
    main_step();
    main_step();
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_ready_after", 64'(port_req_ready), 64'd3);
    check("midrst_inflight_kept", 64'(inflight.size() > 0), 64'd1);
    main_step();
    resp_budget = 1000000;
    repeat (10) @(negedge clk);
    check("midrst_orphan_err", 64'(err_orphan_res), 64'd1);
    check("midrst_idle", 64'(mem_req_valid), 64'd0);

    check("sb_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
